// File: rtl/fpu_addsub_pipe.sv
// fpu_addsub_pipe: pipelined floating-point add/sub with RNE rounding,
// flush-to-zero, special-value bypass and a single global stall.
module fpu_addsub_pipe #(
   parameter int EXP_W  = 8,
   parameter int MANT_W = 23,
   parameter int W      = EXP_W + MANT_W + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] OUT,
   output logic         zflag,
   output logic         ovf,
   output logic         nan
);
   localparam int SW    = MANT_W + 1;
   localparam int XW    = MANT_W + 4;
   localparam int EMAXI = (1 << EXP_W) - 1;
   localparam logic [EXP_W-1:0] EMAX = '1;
   localparam logic [W-1:0] QNAN =
      {1'b0, EMAX, 1'b1, {(MANT_W-1){1'b0}}};

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
   } in_t;

   typedef struct packed {
      logic             bypass;
      logic             isNan;
      logic [W-1:0]     byRes;
      logic             sign;
      logic             effSub;
      logic [EXP_W-1:0] exp;
      logic [XW-1:0]    sigL;
      logic [XW-1:0]    sigS;
   } al_t;

   typedef struct packed {
      logic               bypass;
      logic               isNan;
      logic [W-1:0]       byRes;
      logic               zero;
      logic               sign;
      logic signed [31:0] exp;
      logic [XW-1:0]      mant;
   } nm_t;

   logic advance;
   logic v0, v1, v2;
   in_t  inR;
   al_t  alR, alD;
   nm_t  nmR, nmD;

   assign advance  = out_ready | ~out_valid;
   assign in_ready = advance;

   logic              sA, sB, zA, zB;
   logic              infA, infB, nanA, nanB, aBig;
   logic              cNan, cInfA, cInfB, cZZ, cZB, cZA;
   logic [EXP_W-1:0]  eA, eB, eL, eS;
   logic [MANT_W-1:0] mA, mB, mL, mS;
   logic [31:0]       shAmt;
   logic [SW+1:0]     ext, extSh, lost;

   always_comb begin
      sA   = inR.a[W-1];
      sB   = inR.b[W-1] ^ inR.sub;
      eA   = inR.a[W-2 -: EXP_W];
      eB   = inR.b[W-2 -: EXP_W];
      mA   = inR.a[MANT_W-1:0];
      mB   = inR.b[MANT_W-1:0];
      zA   = (eA == '0);
      zB   = (eB == '0);
      infA = (eA == EMAX) && (mA == '0);
      infB = (eB == EMAX) && (mB == '0);
      nanA = (eA == EMAX) && (mA != '0);
      nanB = (eB == EMAX) && (mB != '0);
      cNan  = nanA | nanB | (infA & infB & (sA ^ sB));
      cInfA = infA & ~cNan;
      cInfB = infB & ~infA & ~cNan;
      cZZ   = zA & zB;
      cZB   = zB & ~zA & (eA != EMAX);
      cZA   = zA & ~zB & (eB != EMAX);
      aBig = {eA, mA} >= {eB, mB};
      eL   = aBig ? eA : eB;
      mL   = aBig ? mA : mB;
      eS   = aBig ? eB : eA;
      mS   = aBig ? mB : mA;
      // Bits pushed below R are caught by shifting them up out of range.
      shAmt = 32'(eL) - 32'(eS);
      ext   = {1'b1, mS, 2'b00};
      extSh = ext >> shAmt;
      lost  = ext << (32'(SW + 2) - shAmt);
      alD        = '0;
      alD.sign   = aBig ? sA : sB;
      alD.effSub = sA ^ sB;
      alD.exp    = eL;
      alD.sigL   = {1'b1, mL, 3'b000};
      if (shAmt >= 32'(SW + 2))
         alD.sigS = {{(XW-1){1'b0}}, 1'b1};
      else
         alD.sigS = {extSh, |lost};
      unique case (1'b1)
         cNan: begin
            alD.bypass = 1'b1;
            alD.isNan  = 1'b1;
            alD.byRes  = QNAN;
         end
         cInfA: begin
            alD.bypass = 1'b1;
            alD.byRes  = inR.a;
         end
         cInfB: begin
            alD.bypass = 1'b1;
            alD.byRes  = {sB, EMAX, {MANT_W{1'b0}}};
         end
         cZZ: begin
            alD.bypass = 1'b1;
            alD.byRes  = {sA & sB, {(W-1){1'b0}}};
         end
         cZB: begin
            alD.bypass = 1'b1;
            alD.byRes  = inR.a;
         end
         cZA: begin
            alD.bypass = 1'b1;
            alD.byRes  = {sB, inR.b[W-2:0]};
         end
         default: ;
      endcase
   end

   logic [XW:0]   sum;
   logic [XW-1:0] diff, nrm;
   logic [31:0]   lz;

   always_comb begin
      nmD        = '0;
      nmD.bypass = alR.bypass;
      nmD.isNan  = alR.isNan;
      nmD.byRes  = alR.byRes;
      nmD.sign   = alR.sign;
      nmD.exp    = $signed(32'(alR.exp));
      sum  = {1'b0, alR.sigL} + {1'b0, alR.sigS};
      diff = alR.sigL - alR.sigS;
      lz   = '0;
      for (int i = 0; i < XW; i++)
         if (diff[i]) lz = 32'(XW - 1 - i);
      nrm = diff << lz;
      if (!alR.effSub) begin
         if (sum[XW]) begin
            nmD.mant = {sum[XW:2], sum[1] | sum[0]};
            nmD.exp  = $signed(32'(alR.exp)) + 32'sd1;
         end else begin
            nmD.mant = sum[XW-1:0];
         end
      end else if (diff == '0) begin
         nmD.zero = 1'b1;
         nmD.sign = 1'b0;
      end else begin
         nmD.mant = nrm;
         nmD.exp  = $signed(32'(alR.exp)) - $signed(lz);
         if (nmD.exp <= 0) nmD.zero = 1'b1;
      end
   end

   logic               inc, ovfD, nanD;
   logic               cBy, cZero, cInf;
   logic [SW:0]        rnd;
   logic [MANT_W-1:0]  frac;
   logic signed [31:0] eR;
   logic [W-1:0]       res;

   always_comb begin
      inc  = nmR.mant[2] & (nmR.mant[1] | nmR.mant[0] | nmR.mant[3]);
      rnd  = {1'b0, nmR.mant[XW-1:3]} + {{SW{1'b0}}, inc};
      eR   = rnd[SW] ? nmR.exp + 32'sd1 : nmR.exp;
      frac = rnd[SW] ? rnd[MANT_W:1] : rnd[MANT_W-1:0];
      cBy   = nmR.bypass;
      cZero = ~nmR.bypass & nmR.zero;
      cInf  = ~nmR.bypass & ~nmR.zero & (eR >= EMAXI);
      res  = {nmR.sign, eR[EXP_W-1:0], frac};
      ovfD = 1'b0;
      nanD = 1'b0;
      unique case (1'b1)
         cBy: begin
            res  = nmR.byRes;
            nanD = nmR.isNan;
         end
         cZero: res = {nmR.sign, {(W-1){1'b0}}};
         cInf: begin
            res  = {nmR.sign, EMAX, {MANT_W{1'b0}}};
            ovfD = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v0        <= 1'b0;
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
         OUT       <= '0;
         zflag     <= 1'b0;
         ovf       <= 1'b0;
         nan       <= 1'b0;
      end else if (advance) begin
         v0        <= in_valid;
         v1        <= v0;
         v2        <= v1;
         out_valid <= v2;
         if (v2) begin
            OUT   <= res;
            zflag <= (res[W-2 -: EXP_W] == '0);
            ovf   <= ovfD;
            nan   <= nanD;
         end
      end
   end

   // Payload registers carry don't-care data behind bubbles.
   always_ff @(posedge clk) begin
      if (advance) begin
         inR <= '{a: A, b: B, sub: sub};
         alR <= alD;
         nmR <= nmD;
      end
   end

endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// tb_fpu_addsub_pipe: scoreboard bench for a single and a half precision
// instance: vector table, backpressure, reset mid-stream, random sweep.
module tb_fpu_addsub_pipe;
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] res;
      logic        z;
      logic        o;
      logic        n;
   } vec_t;

   typedef struct packed {
      logic [31:0] res;
      logic        z;
      logic        o;
      logic        n;
   } exp_t;

   logic        clk, rst;
   logic        sValid, sReady, sSub, sOutValid, sOutReady;
   logic        sZ, sO, sN;
   logic [31:0] sA, sB, sOut;
   logic        hValid, hReady, hSub, hOutValid, hOutReady;
   logic        hZ, hO, hN;
   logic [15:0] hA, hB, hOut;

   exp_t sq[$], hq[$];
   exp_t sCur, hCur;
   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   fpu_addsub_pipe uS (
      .clk(clk), .rst(rst),
      .in_valid(sValid), .in_ready(sReady),
      .A(sA), .B(sB), .sub(sSub),
      .out_valid(sOutValid), .out_ready(sOutReady),
      .OUT(sOut), .zflag(sZ), .ovf(sO), .nan(sN)
   );

   fpu_addsub_pipe #(.EXP_W(5), .MANT_W(10)) uH (
      .clk(clk), .rst(rst),
      .in_valid(hValid), .in_ready(hReady),
      .A(hA), .B(hB), .sub(hSub),
      .out_valid(hOutValid), .out_ready(hOutReady),
      .OUT(hOut), .zflag(hZ), .ovf(hO), .nan(hN)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(input string name,
                                 input logic [31:0] act,
                                 input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t",
                  name, act, want, $time);
      end
   endfunction

   function automatic void addv(input logic [31:0] a, b,
                                input logic s,
                                input logic [31:0] r,
                                input logic z, o, n);
      vec_t v;
      v = '{a: a, b: b, sub: s, res: r, z: z, o: o, n: n};
      tbl.push_back(v);
   endfunction

   // Exact-integer half precision reference: RNE, flush-to-zero.
   function automatic exp_t refH(input logic [15:0] a, b,
                                 input logic s);
      exp_t r;
      logic sa, sb;
      logic [4:0] ea, eb;
      logic [9:0] ma, mb;
      longint va, vb, sm, mag, q, rem, hlf;
      int p, e, sh;
      r  = '0;
      sa = a[15];
      sb = b[15] ^ s;
      ea = a[14:10];
      eb = b[14:10];
      ma = a[9:0];
      mb = b[9:0];
      if ((ea == 31 && ma != 0) || (eb == 31 && mb != 0) ||
          (ea == 31 && eb == 31 && sa != sb)) begin
         r.res = 32'h7E00;
         r.n   = 1'b1;
      end else if (ea == 31) r.res = {16'h0, a};
      else if (eb == 31) r.res = {16'h0, sb, 15'h7C00};
      else if (ea == 0 && eb == 0) r.res = {16'h0, sa & sb, 15'h0};
      else if (eb == 0) r.res = {16'h0, a};
      else if (ea == 0) r.res = {16'h0, sb, b[14:0]};
      else begin
         va = longint'({1'b1, ma}) << (ea - 1);
         vb = longint'({1'b1, mb}) << (eb - 1);
         sm = (sa ? -va : va) + (sb ? -vb : vb);
         if (sm != 0) begin
            mag = (sm < 0) ? -sm : sm;
            p = 0;
            for (int i = 0; i < 63; i++) if (mag[i]) p = i;
            e = p - 9;
            if (e <= 0) r.res = {16'h0, sm < 0, 15'h0};
            else begin
               sh  = p - 10;
               q   = mag >> sh;
               rem = mag - (q << sh);
               if (sh > 0) begin
                  hlf = longint'(1) << (sh - 1);
                  if (rem > hlf || (rem == hlf && q[0])) q++;
               end
               if (q == 2048) begin
                  q = q >> 1;
                  e++;
               end
               if (e >= 31) begin
                  r.res = {16'h0, sm < 0, 15'h7C00};
                  r.o   = 1'b1;
               end else begin
                  r.res = {16'h0, sm < 0, 5'(e), q[9:0]};
               end
            end
         end
      end
      r.z = (r.res[14:10] == 5'd0);
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         sq.delete();
         hq.delete();
      end else begin
         check("s_in_ready", {31'b0, sReady},
               {31'b0, sOutReady | ~sOutValid});
         if (sOutValid) begin
            if (sq.size() == 0) check("s_spurious", {31'b0, sOutValid}, 0);
            else begin
               check("s_out", sOut, sq[0].res);
               check("s_zflag", {31'b0, sZ}, {31'b0, sq[0].z});
               check("s_ovf", {31'b0, sO}, {31'b0, sq[0].o});
               check("s_nan", {31'b0, sN}, {31'b0, sq[0].n});
               if (sOutReady) void'(sq.pop_front());
            end
         end
         if (sValid && sReady) sq.push_back(sCur);
         if (hOutValid) begin
            if (hq.size() == 0) check("h_spurious", {31'b0, hOutValid}, 0);
            else begin
               check("h_out", {16'h0, hOut}, hq[0].res);
               check("h_flags", {29'b0, hZ, hO, hN},
                     {29'b0, hq[0].z, hq[0].o, hq[0].n});
               if (hOutReady) void'(hq.pop_front());
            end
         end
         if (hValid && hReady) hq.push_back(hCur);
      end
   end

   task automatic sendS(input vec_t v, input bit rndRdy);
      bit acc = 1'b0;
      sA     = v.a;
      sB     = v.b;
      sSub   = v.sub;
      sCur   = '{res: v.res, z: v.z, o: v.o, n: v.n};
      sValid = 1'b1;
      for (int n = 0; n < 200 && !acc; n++) begin
         if (rndRdy) sOutReady = 1'($urandom_range(0, 1));
         @(negedge clk);
         acc = sReady;
         @(posedge clk);
         #1;
      end
      if (!acc) check("s_accept", {31'b0, acc}, 1);
   endtask

   task automatic sendH(input logic [15:0] a, b, input logic s);
      bit acc = 1'b0;
      hA     = a;
      hB     = b;
      hSub   = s;
      hCur   = refH(a, b, s);
      hValid = 1'b1;
      for (int n = 0; n < 200 && !acc; n++) begin
         hOutReady = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc = hReady;
         @(posedge clk);
         #1;
      end
      if (!acc) check("h_accept", {31'b0, acc}, 1);
   endtask

   task automatic drain(input bit rndRdy);
      sValid = 1'b0;
      hValid = 1'b0;
      for (int n = 0; n < 400 && (sq.size() + hq.size()) != 0; n++) begin
         sOutReady = rndRdy ? 1'($urandom_range(0, 1)) : 1'b1;
         hOutReady = 1'b1;
         @(posedge clk);
         #1;
      end
      check("drain_left", 32'(sq.size() + hq.size()), 0);
      sOutReady = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat;
      bit acc;
      logic [15:0] ra, rb;
      rst = 1'b1;
      sValid = 0; sA = 0; sB = 0; sSub = 0; sOutReady = 1;
      hValid = 0; hA = 0; hB = 0; hSub = 0; hOutReady = 1;
      sCur = '0;
      hCur = '0;
      addv(32'h3F800000, 32'h40000000, 0, 32'h40400000, 0, 0, 0);
      addv(32'h40400000, 32'h40400000, 1, 32'h00000000, 1, 0, 0);
      addv(32'h3F800000, 32'h33800000, 0, 32'h3F800000, 0, 0, 0);
      addv(32'h3F800001, 32'h33800000, 0, 32'h3F800002, 0, 0, 0);
      addv(32'h7F7FFFFF, 32'h7F7FFFFF, 0, 32'h7F800000, 0, 1, 0);
      addv(32'h7F800000, 32'h7F800000, 1, 32'h7FC00000, 0, 0, 1);
      addv(32'h40A00000, 32'h00000000, 0, 32'h40A00000, 0, 0, 0);
      addv(32'h3F800000, 32'h40000000, 1, 32'hBF800000, 0, 0, 0);
      addv(32'hC0000000, 32'h3F800000, 0, 32'hBF800000, 0, 0, 0);
      addv(32'h7FC00001, 32'h3F800000, 0, 32'h7FC00000, 0, 0, 1);
      addv(32'h7F800000, 32'h3F800000, 0, 32'h7F800000, 0, 0, 0);
      addv(32'h3F800000, 32'hFF800000, 1, 32'h7F800000, 0, 0, 0);
      addv(32'h00000000, 32'h3F800000, 1, 32'hBF800000, 0, 0, 0);
      addv(32'h80000000, 32'h80000000, 0, 32'h80000000, 1, 0, 0);
      addv(32'h80000000, 32'h80000000, 1, 32'h00000000, 1, 0, 0);
      addv(32'h00400000, 32'h00000000, 0, 32'h00000000, 1, 0, 0);
      addv(32'h00C00000, 32'h00800000, 1, 32'h00000000, 1, 0, 0);
      addv(32'h00800000, 32'h00C00000, 1, 32'h80000000, 1, 0, 0);
      addv(32'h3FC00000, 32'h3FC00000, 0, 32'h40400000, 0, 0, 0);
      addv(32'h3F800000, 32'hBF800000, 0, 32'h00000000, 1, 0, 0);
      addv(32'h7F800000, 32'h7F800000, 0, 32'h7F800000, 0, 0, 0);
      addv(32'h3F800000, 32'h00800000, 1, 32'h3F800000, 0, 0, 0);

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", {31'b0, sOutValid}, 0);
      check("rst_out", sOut, 0);
      check("rst_flags", {29'b0, sZ, sO, sN}, 0);
      check("rst_in_ready", {31'b0, sReady}, 1);
      @(posedge clk);
      #1;

      foreach (tbl[i]) sendS(tbl[i], 1'b0);
      drain(1'b0);

      for (int i = 0; i < 16; i++) sendS(tbl[(i * 5) % tbl.size()], 1'b1);
      drain(1'b1);

      sOutReady = 1'b1;
      sendS(tbl[0], 1'b0);
      sendS(tbl[7], 1'b0);
      sendS(tbl[18], 1'b0);
      sValid = 1'b0;
      rst    = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("rst_no_stale", {31'b0, sOutValid}, 0);
         @(posedge clk);
         #1;
      end

      sA     = tbl[3].a;
      sB     = tbl[3].b;
      sSub   = tbl[3].sub;
      sCur   = '{res: tbl[3].res, z: tbl[3].z, o: tbl[3].o, n: tbl[3].n};
      sValid = 1'b1;
      @(negedge clk);
      acc = sReady;
      check("lat_accept", {31'b0, acc}, 1);
      @(posedge clk);
      #1 sValid = 1'b0;
      lat = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (sOutValid) break;
         @(posedge clk);
         lat++;
      end
      check("latency", 32'(lat), 3);
      @(posedge clk);
      #1;
      drain(1'b0);

      sendH(16'h3C00, 16'h4000, 1'b0);
      sendH(16'h7BFF, 16'h7BFF, 1'b0);
      sendH(16'h0600, 16'h0400, 1'b1);
      for (int i = 0; i < 10000; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if ($urandom_range(0, 1) == 1)
            rb[14:10] = ra[14:10] + 5'($urandom_range(0, 2)) - 5'd1;
         sendH(ra, rb, 1'($urandom_range(0, 1)));
      end
      drain(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
